// File: rtl/dsp_pkg.sv
// Shared types and defaults for the audio DSP frame sequencer.
package dsp_pkg;

    localparam int DSP_DW           = 32;
    localparam int DSP_PROC_TIMEOUT = 64;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_CFG     = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_FETCH   = S_FETCH,
        ST_CAPTURE = S_CAPTURE,
        ST_RUN     = S_RUN,
        ST_DRAIN   = S_DRAIN,
        ST_CFG     = S_CFG
    } dsp_state_e;

endpackage

// File: rtl/dsp_seq_ctrl_if.sv
// FIFO, datapath and config handshake bundle around the frame sequencer.
interface dsp_seq_ctrl_if
    import dsp_pkg::*;
#(
    parameter int DW = DSP_DW
);
    logic                 dsp_en;
    logic                 empty;
    logic                 read_en;
    logic signed [DW-1:0] left_din;
    logic signed [DW-1:0] right_din;
    logic signed [DW-1:0] left_q;
    logic signed [DW-1:0] right_q;
    logic                 proc_start;
    logic                 proc_done;
    logic signed [DW-1:0] ch1_res;
    logic signed [DW-1:0] ch2_res;
    logic signed [DW-1:0] ch1_dout;
    logic signed [DW-1:0] ch2_dout;
    logic                 full;
    logic                 write_en;
    logic                 cfg_req;
    logic                 cfg_ack;
    logic [15:0]          frame_cnt;
    logic                 err_timeout;

    modport master (
        output dsp_en, empty, left_din, right_din,
        output proc_done, ch1_res, ch2_res,
        output full, cfg_req,
        input  read_en, left_q, right_q, proc_start,
        input  ch1_dout, ch2_dout, write_en,
        input  cfg_ack, frame_cnt, err_timeout
    );

    modport slave (
        input  dsp_en, empty, left_din, right_din,
        input  proc_done, ch1_res, ch2_res,
        input  full, cfg_req,
        output read_en, left_q, right_q, proc_start,
        output ch1_dout, ch2_dout, write_en,
        output cfg_ack, frame_cnt, err_timeout
    );

endinterface

// File: rtl/dsp_seq_ctrl.sv
// Frame sequencer: pops one stereo sample, runs the datapath, pushes the
// result, and grants coefficient updates only between frames.
module dsp_seq_ctrl
    import dsp_pkg::*;
#(
    parameter int DW           = DSP_DW,
    parameter int PROC_TIMEOUT = DSP_PROC_TIMEOUT
) (
    input  logic          adsp_clk,
    input  logic          rst_n,
    dsp_seq_ctrl_if.slave bus
);

    localparam int            TW       = $clog2(PROC_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(PROC_TIMEOUT);

    dsp_state_e state;
    dsp_state_e state_nx;

    logic [TW-1:0]        tmo_cnt;
    logic                 read_en_r;
    logic                 proc_start_r;
    logic                 write_en_r;
    logic                 cfg_ack_r;
    logic signed [DW-1:0] left_q_r;
    logic signed [DW-1:0] right_q_r;
    logic signed [DW-1:0] ch1_r;
    logic signed [DW-1:0] ch2_r;
    logic [15:0]          frame_cnt_r;
    logic                 err_r;

    logic done_ok;
    logic tmo_hit;

    // The start cycle itself never accepts a done; a done on the
    // timeout cycle still wins over the timeout.
    assign done_ok = (state == ST_RUN) && !proc_start_r && bus.proc_done;
    assign tmo_hit = (state == ST_RUN) && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.cfg_req)
                    state_nx = ST_CFG;
                else if (bus.dsp_en && !bus.empty)
                    state_nx = ST_FETCH;
            end
            ST_FETCH:   state_nx = ST_CAPTURE;
            ST_CAPTURE: state_nx = ST_RUN;
            ST_RUN: begin
                if (done_ok)
                    state_nx = ST_DRAIN;
                else if (tmo_hit)
                    state_nx = ST_IDLE;
            end
            ST_DRAIN: begin
                if (!bus.full)
                    state_nx = ST_IDLE;
            end
            ST_CFG:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge adsp_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            read_en_r    <= 1'b0;
            proc_start_r <= 1'b0;
            write_en_r   <= 1'b0;
            cfg_ack_r    <= 1'b0;
        end else begin
            state        <= state_nx;
            read_en_r    <= (state_nx == ST_FETCH);
            proc_start_r <= (state == ST_CAPTURE);
            write_en_r   <= (state == ST_DRAIN) && !bus.full;
            cfg_ack_r    <= (state_nx == ST_CFG);
        end
    end

    always_ff @(posedge adsp_clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == ST_CAPTURE) begin
            tmo_cnt <= '0;
        end else if (state == ST_RUN) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    always_ff @(posedge adsp_clk or negedge rst_n) begin
        if (!rst_n) begin
            left_q_r  <= '0;
            right_q_r <= '0;
            ch1_r     <= '0;
            ch2_r     <= '0;
        end else begin
            if (state == ST_CAPTURE) begin
                left_q_r  <= bus.left_din;
                right_q_r <= bus.right_din;
            end
            if (done_ok) begin
                ch1_r <= bus.ch1_res;
                ch2_r <= bus.ch2_res;
            end
        end
    end

    always_ff @(posedge adsp_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= '0;
            err_r       <= 1'b0;
        end else begin
            if ((state == ST_DRAIN) && !bus.full)
                frame_cnt_r <= frame_cnt_r + 16'd1;
            if (tmo_hit && !done_ok)
                err_r <= 1'b1;
        end
    end

    assign bus.read_en     = read_en_r;
    assign bus.proc_start  = proc_start_r;
    assign bus.write_en    = write_en_r;
    assign bus.cfg_ack     = cfg_ack_r;
    assign bus.left_q      = left_q_r;
    assign bus.right_q     = right_q_r;
    assign bus.ch1_dout    = ch1_r;
    assign bus.ch2_dout    = ch2_r;
    assign bus.frame_cnt   = frame_cnt_r;
    assign bus.err_timeout = err_r;

endmodule
